eq1_solution_gen: RTL and testbench

// - Transmit side of the equation-1 operand interface: builds a valid (x, y, z) for (x/z)^2 + y/z == {1'b1, OngoingTimer}.
// - Drives the equation checker's DataIn/Go/startEq1 inputs, e.g. for the auto-solve/hint mode or the self-test bench.
// - Solution uses 8-bit unsigned truncating ALU rules: q = floor(sqrt(T)), r = T - q*q, x = q*z, y = r*z.

---
 rtl/eq_pkg.sv | 14 +
 rtl/eq1_handshake_tx.sv | 83 ++++++++
 rtl/eq1_solution_gen.sv | 139 +++++++++++++
 tb/tb_eq1_solution_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared states, widths and operand indices for the equation-1 solver
package eq_pkg;

  typedef enum logic [2:0] {IDLE, SQRT, ZSEL, MUL, SETUP, GO_HI, GO_LO} state_t;

  localparam logic TARGET_MSB = 1'b1;
  localparam int   DATA_W     = 8;
  localparam int   TIMER_W    = 7;

  localparam logic [1:0] OP_X = 2'd0;
  localparam logic [1:0] OP_Y = 2'd1;
  localparam logic [1:0] OP_Z = 2'd2;

endpackage

// File: rtl/eq1_handshake_tx.sv
// rtl/eq1_handshake_tx.sv - drives one operand onto DataOut with a SETUP / Go-high / Go-low strobe
module eq1_handshake_tx
  import eq_pkg::*;
#(
  parameter int GO_CYCLES  = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic [DATA_W-1:0] DataOut,
  output logic              Go,
  output logic              op_done
);

  localparam int             CNT_W    = 16;
  localparam logic [CNT_W-1:0] GO_LAST  = CNT_W'(GO_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    op_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          data_d  = operand_i;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = GO_HI;
      end
      GO_HI: begin
        if (cnt_q == GO_LAST) begin
          cnt_d   = '0;
          state_d = GO_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GO_LO: begin
        if (cnt_q == GAP_LAST) begin
          op_done = 1'b1;
          // Accepting the next operand here keeps SETUP back-to-back with the previous gap.
          if (load_i) begin
            data_d  = operand_i;
            state_d = SETUP;
          end else begin
            data_d  = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Go      = (state_q == GO_HI);
  assign DataOut = (state_q == IDLE) ? '0 : data_q;

endmodule

// File: rtl/eq1_solution_gen.sv
// rtl/eq1_solution_gen.sv - solves (x/z)^2 + y/z == {1, OngoingTimer} and streams x, y, z to the checker
module eq1_solution_gen
  import eq_pkg::*;
#(
  parameter int Z_MAX      = 8,
  parameter int GO_CYCLES  = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               start,
  input  logic [TIMER_W-1:0] OngoingTimer,
  output logic               startEq1,
  output logic [DATA_W-1:0]  DataOut,
  output logic               Go,
  output logic               busy,
  output logic               done
);

  state_t            state_q, state_d;
  logic [7:0]        t_q, t_d;
  logic [3:0]        q_q, q_d;
  logic [7:0]        r_q, r_d;
  logic [7:0]        z_q, z_d;
  logic [7:0]        y_q, y_d;
  logic [1:0]        op_q, op_d;
  logic              done_q, done_d;

  logic [4:0]        q_inc;
  logic [8:0]        sq_next;
  logic [7:0]        sq_cur;
  logic [15:0]       prod_x, prod_y;
  logic              tx_load, tx_done;
  logic [DATA_W-1:0] tx_operand;

  assign q_inc   = {1'b0, q_q} + 5'd1;
  assign sq_next = {4'b0, q_inc} * {4'b0, q_inc};
  assign sq_cur  = {4'b0, q_q} * {4'b0, q_q};
  assign prod_x  = {12'b0, q_q} * {8'b0, z_q};
  assign prod_y  = {8'b0, r_q} * {8'b0, z_q};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      z_q     <= '0;
      y_q     <= '0;
      op_q    <= OP_X;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      q_q     <= q_d;
      r_q     <= r_d;
      z_q     <= z_d;
      y_q     <= y_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  // SETUP stands for the whole transmit phase here; the transmitter tracks its own sub-phases.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    q_d        = q_q;
    r_d        = r_q;
    z_d        = z_q;
    y_d        = y_q;
    op_d       = op_q;
    done_d     = 1'b0;
    tx_load    = 1'b0;
    tx_operand = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          t_d     = {TARGET_MSB, OngoingTimer};
          q_d     = '0;
          r_d     = '0;
          state_d = SQRT;
        end
      end
      SQRT: begin
        if (sq_next <= {1'b0, t_q}) begin
          q_d = q_q + 4'd1;
        end else begin
          r_d     = t_q - sq_cur;
          z_d     = 8'(Z_MAX);
          state_d = ZSEL;
        end
      end
      ZSEL: begin
        if (prod_x <= 16'd255 && prod_y <= 16'd255) state_d = MUL;
        else z_d = z_q - 8'd1;
      end
      MUL: begin
        // x goes straight into the transmitter; only y needs holding for later.
        tx_load    = 1'b1;
        tx_operand = prod_x[7:0];
        y_d        = prod_y[7:0];
        op_d       = OP_X;
        state_d    = SETUP;
      end
      SETUP: begin
        if (tx_done) begin
          if (op_q == OP_Z) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tx_load    = 1'b1;
            tx_operand = (op_q == OP_X) ? y_q : z_q;
            op_d       = op_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  eq1_handshake_tx #(
    .GO_CYCLES (GO_CYCLES),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_tx (
    .Clock    (Clock),
    .Reset    (Reset),
    .load_i   (tx_load),
    .operand_i(tx_operand),
    .DataOut  (DataOut),
    .Go       (Go),
    .op_done  (tx_done)
  );

  assign startEq1 = (state_q == IDLE) && start && !Reset;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_eq1_solution_gen.sv
// tb/tb_eq1_solution_gen.sv - randomized and directed checks of eq1_solution_gen against an arithmetic model
module tb_eq1_solution_gen;

  localparam int GO_CYCLES  = 4;
  localparam int GAP_CYCLES = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       start8, start32;
  logic [6:0] tmr8, tmr32;
  logic       se8, se32, go8, go32, busy8, busy32, done8, done32;
  logic [7:0] d8, d32;

  int vectors     = 0;
  int miscompares = 0;
  bit sel         = 1'b0;

  logic       se_s, go_s, busy_s, done_s;
  logic [7:0] d_s;

  assign se_s   = sel ? se32   : se8;
  assign go_s   = sel ? go32   : go8;
  assign busy_s = sel ? busy32 : busy8;
  assign done_s = sel ? done32 : done8;
  assign d_s    = sel ? d32    : d8;

  always #5 Clock = ~Clock;

  eq1_solution_gen #(.Z_MAX(8), .GO_CYCLES(GO_CYCLES), .GAP_CYCLES(GAP_CYCLES)) dut8 (
    .Clock(Clock), .Reset(Reset), .start(start8), .OngoingTimer(tmr8),
    .startEq1(se8), .DataOut(d8), .Go(go8), .busy(busy8), .done(done8)
  );

  eq1_solution_gen #(.Z_MAX(32), .GO_CYCLES(GO_CYCLES), .GAP_CYCLES(GAP_CYCLES)) dut32 (
    .Clock(Clock), .Reset(Reset), .start(start32), .OngoingTimer(tmr32),
    .startEq1(se32), .DataOut(d32), .Go(go32), .busy(busy32), .done(done32)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] t);
    if (sel) begin start32 = v; tmr32 = t; end
    else     begin start8  = v; tmr8  = t; end
  endtask

  // Reference: integer square root, then the largest divisor keeping both products in a byte.
  task automatic model(input int tmr, input int zmax,
                       output int x, output int y, output int z, output int lat);
    int t, q, r;
    t = 128 + tmr;
    q = 0;
    while ((q + 1) * (q + 1) <= t) q++;
    r = t - q * q;
    z = zmax;
    while (q * z > 255 || r * z > 255) z--;
    x = q * z;
    y = r * z;
    lat = 1 + (q + 1) + (zmax - z + 1) + 1 + 3 * (1 + GO_CYCLES + GAP_CYCLES);
  endtask

  task automatic do_txn(input bit s, input logic [6:0] tmr, input bit spam,
                        input int ex, input int ey, input int ez, input int lat);
    int run, nops;
    bit pg, seen_done;
    logic [7:0] pd;
    logic [7:0] ops [3];
    sel = s;
    ops = '{8'd0, 8'd0, 8'd0};
    @(negedge Clock);
    drive(1'b1, tmr);
    #1;
    chk("startEq1_pulse", 16'(se_s), 16'd1);
    chk("busy_before_start", 16'(busy_s), 16'd0);
    pg = 1'b0; pd = '0; run = 0; nops = 0; seen_done = 1'b0;
    for (int k = 1; k <= lat + 20 && !seen_done; k++) begin
      @(negedge Clock);
      drive(1'b0, 7'($urandom));
      if (spam && (k % 5 == 0) && k < lat - 2) begin
        drive(1'b1, 7'($urandom));
        #1;
        chk("start_ignored", 16'(se_s), 16'd0);
      end
      if (go_s && !pg) begin
        chk("setup_stable", 16'(d_s), 16'(pd));
        if (nops < 3) ops[nops] = d_s;
        nops++;
        run = 1;
      end else if (go_s && pg) begin
        chk("go_data_stable", 16'(d_s), 16'(pd));
        run++;
      end else if (!go_s && pg) begin
        chk("go_run_len", 16'(run), 16'(GO_CYCLES));
      end
      if (done_s) begin
        seen_done = 1'b1;
        chk("latency", 16'(k), 16'(lat));
        chk("busy_at_done", 16'(busy_s), 16'd0);
      end else begin
        chk("busy_during", 16'(busy_s), 16'd1);
      end
      pg = go_s;
      pd = d_s;
    end
    chk("done_seen", 16'(seen_done), 16'd1);
    chk("operand_count", 16'(nops), 16'd3);
    chk("x_value", 16'(ops[0]), 16'(ex));
    chk("y_value", 16'(ops[1]), 16'(ey));
    chk("z_value", 16'(ops[2]), 16'(ez));
    @(negedge Clock);
    drive(1'b0, 7'd0);
    chk("done_one_cycle", 16'(done_s), 16'd0);
    chk("data_idle_zero", 16'(d_s), 16'd0);
  endtask

  initial begin
    int mx, my, mz, ml, rises, dones;
    bit pg;
    logic [6:0] rt;
    Reset = 1'b1;
    start8 = 1'b0; start32 = 1'b0; tmr8 = '0; tmr32 = '0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("rst_busy", 16'(busy8), 16'd0);
    chk("rst_go", 16'(go8), 16'd0);
    chk("rst_data", 16'(d8), 16'd0);
    chk("rst_done", 16'(done8), 16'd0);
    chk("rst_startEq1", 16'(se8), 16'd0);
    chk("rst_busy32", 16'(busy32), 16'd0);

    model(0, 8, mx, my, mz, ml);
    do_txn(1'b0, 7'd0, 1'b0, 88, 56, 8, ml);
    model(127, 8, mx, my, mz, ml);
    do_txn(1'b0, 7'd127, 1'b1, 120, 240, 8, ml);
    model(100, 8, mx, my, mz, ml);
    do_txn(1'b0, 7'd100, 1'b0, 120, 24, 8, ml);
    model(0, 32, mx, my, mz, ml);
    do_txn(1'b1, 7'd0, 1'b1, 253, 161, 23, ml);

    for (int i = 0; i < 6; i++) begin
      rt = 7'($urandom);
      model(int'(rt), 8, mx, my, mz, ml);
      do_txn(1'b0, rt, 1'($urandom), mx, my, mz, ml);
      rt = 7'($urandom);
      model(int'(rt), 32, mx, my, mz, ml);
      do_txn(1'b1, rt, 1'($urandom), mx, my, mz, ml);
    end

    // Abort during y's Go-high window, then confirm nothing resumes.
    sel = 1'b0;
    @(negedge Clock);
    drive(1'b1, 7'd55);
    @(negedge Clock);
    drive(1'b0, 7'd0);
    rises = 0; pg = 1'b0;
    for (int k = 0; k < 200 && rises < 2; k++) begin
      @(negedge Clock);
      if (go_s && !pg) rises++;
      pg = go_s;
    end
    chk("reached_y_go_hi", 16'(rises), 16'd2);
    Reset = 1'b1;
    @(negedge Clock);
    chk("abort_go", 16'(go_s), 16'd0);
    chk("abort_data", 16'(d_s), 16'd0);
    chk("abort_busy", 16'(busy_s), 16'd0);
    chk("abort_done", 16'(done_s), 16'd0);
    Reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clock);
      if (done_s || go_s) dones++;
    end
    chk("no_resume", 16'(dones), 16'd0);
    model(55, 8, mx, my, mz, ml);
    do_txn(1'b0, 7'd55, 1'b0, mx, my, mz, ml);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
